bcd_convert_ctrl: RTL and testbench

- Sequential, multi-cycle binary-to-BCD converter controller for the CPU's seven-segment display path.
- Accepts one binary word over a valid/ready handshake and runs double dabble one bit per clock (MSB first).
- Holds the packed BCD result until it is consumed.
- Replaces a fully unrolled combinational converter on timing-critical display paths.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/bcd_convert_ctrl.sv | 153 +++++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W    : width of one BCD digit
//   ADJ_THRESH : digit value at or above which double dabble adds 3
//   state_t    : controller state encoding
//   cnt_width  : bits needed for a down-counter that starts at n-1
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    // Smallest w (at least 1) with 2^w >= n, which always holds n-1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for a single BCD digit.
//   din  : current digit value
//   dout : din + 3 when din >= 5, otherwise din (4-bit result)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Multi-cycle binary-to-BCD converter (double dabble, one input bit per clock,
// MSB first). One word is accepted over a valid/ready handshake; the packed
// BCD result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   in_valid/in_ready/in_data        : input handshake and binary word
//   out_valid/out_ready              : result handshake
//   out_bcd       : packed BCD, digit 0 (ones) in bits [3:0]
//   out_overflow  : input value was >= 10^DIGITS (out_bcd holds value mod 10^DIGITS)
//   out_negative  : sign of the input (constant 0 in the unsigned build)
//   busy          : conversion running or result pending
//
// Build option: define BCD_SIGNED_EN to treat in_data as two's complement;
// the magnitude is converted and the sign is reported on out_negative.
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 15,
    parameter int DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                    out_overflow,
    output logic                    out_negative,
    output logic                    busy
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(IN_WIDTH);

    state_t              state_q, state_d;
    logic                load, shift;
    logic [CNT_W-1:0]    cnt_q;
    logic [IN_WIDTH-1:0] sreg_q;
    logic [IN_WIDTH-1:0] in_mag;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic                ovf_q;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef BCD_SIGNED_EN
    logic neg_q;

    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude, so no extra bit is needed.
    assign in_mag = in_data[IN_WIDTH-1] ? (~in_data + IN_WIDTH'(1)) : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= in_data[IN_WIDTH-1];
        end
    end

    assign out_negative = neg_q;
`else
    assign in_mag       = in_data;
    assign out_negative = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order across processes.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (bcd_q[i*DIGIT_W +: DIGIT_W]),
            .dout (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sreg_q <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            cnt_q  <= CNT_W'(IN_WIDTH - 1);
            sreg_q <= in_mag;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (shift) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            sreg_q <= {sreg_q[IN_WIDTH-2:0], 1'b0};
            bcd_q  <= {bcd_adj[BCD_W-2:0], sreg_q[IN_WIDTH-1]};
            // The carry out of the top digit means the running value has
            // reached 10^DIGITS; the remaining digits keep value mod 10^DIGITS.
            ovf_q  <= ovf_q | bcd_adj[BCD_W-1];
        end
    end

    assign out_bcd      = bcd_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Scoreboard bench for bcd_convert_ctrl: the driver pushes hand-computed
// results when it offers a word; a negedge monitor pops and compares each
// time the DUT presents a new result, including the accept-to-valid latency.
// Define BCD_SIGNED_EN for both bench and RTL to exercise the signed build.
module tb_bcd_convert_ctrl;

    localparam int IN_WIDTH = 15;
    localparam int DIGITS   = 4;
    localparam int LAT      = 15;

`ifdef BCD_SIGNED_EN
    localparam logic SIGNED_BUILD = 1'b1;
`else
    localparam logic SIGNED_BUILD = 1'b0;
`endif

    logic                  clk       = 1'b0;
    logic                  reset     = 1'b1;
    logic                  in_valid  = 1'b0;
    logic [IN_WIDTH-1:0]   in_data   = '0;
    logic                  out_ready = 1'b1;
    logic                  in_ready;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_overflow;
    logic                  out_negative;
    logic                  busy;

    bcd_convert_ctrl #(
        .IN_WIDTH (IN_WIDTH),
        .DIGITS   (DIGITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_overflow (out_overflow),
        .out_negative (out_negative),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        neg;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison set per presented result.
    logic seen = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected no output", out_bcd);
            end else begin
                mon_e = sb.pop_front();
                check("result_bcd", 32'(out_bcd), 32'(mon_e.bcd));
                check("result_overflow", 32'(out_overflow), 32'(mon_e.ovf));
                check("result_negative", 32'(out_negative), 32'(mon_e.neg));
                check("result_latency", 32'(cyc - mon_e.acc), 32'(LAT));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // Offer one word, push its expected result, return just after the accept edge.
    task automatic send(input logic [IN_WIDTH-1:0] v, input logic [15:0] eb,
                        input logic eo, input logic en);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for data %0h", v);
            in_valid = 1'b0;
        end else begin
            e.bcd = eb;
            e.ovf = eo;
            e.neg = en;
            e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && in_ready && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_bcd", 32'(out_bcd), 32'd0);
        check("reset_overflow", 32'(out_overflow), 32'd0);
        check("reset_negative", 32'(out_negative), 32'd0);
        reset = 1'b0;

        // Zero, largest in-range, first overflowing value, back to back
        send(15'd0,     16'h0000, 1'b0, 1'b0);
        send(15'd9999,  16'h9999, 1'b0, 1'b0);
        send(15'd10000, 16'h0000, 1'b1, 1'b0);
        wait_idle();

        // Backpressure: result held for 20 cycles, extra input ignored
        out_ready = 1'b0;
        send(15'd12345, 16'h2345, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached_done", 32'(out_valid), 32'd1);
        in_data  = 15'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_bcd", 32'(out_bcd), 32'h2345);
            check("hold_overflow", 32'(out_overflow), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // in_valid/in_data activity during CONVERT has no effect
        send(15'd4321, 16'h4321, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in_data  = 15'd1234;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("convert_busy", 32'(busy), 32'd1);
        check("convert_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a conversion aborts it
        send(15'd999, 16'h0999, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        send(15'd42, 16'h0042, 1'b0, 1'b0);
        wait_idle();

        // Patterns whose result depends on the signed build option
        if (SIGNED_BUILD) begin
            send(15'h7FD6, 16'h0042, 1'b0, 1'b1);   // -42
            send(15'h4000, 16'h6384, 1'b1, 1'b1);   // -16384
            send(15'h7FFF, 16'h0001, 1'b0, 1'b1);   // -1
        end else begin
            send(15'h7FD6, 16'h2726, 1'b1, 1'b0);   // 32726
            send(15'h4000, 16'h6384, 1'b1, 1'b0);   // 16384
            send(15'h7FFF, 16'h2767, 1'b1, 1'b0);   // 32767
        end
        send(15'd1,    16'h0001, 1'b0, 1'b0);
        send(15'd5678, 16'h5678, 1'b0, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
